// File: rtl/alu.sv
// rtl/alu.sv - registered two's-complement arithmetic/logic unit
//
// Decodes a 6-bit function code into add/subtract, multiply, Boolean,
// shift and compare operations. The result and the adder flags are
// registered, so every operation has one cycle of latency.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset (clears out and flags)
//   a      in   operand A
//   b      in   operand B (low $clog2(WIDTH) bits give the shift amount)
//   alufn  in   function code; [5:4] selects arith/Boolean/shift/compare
//   out    out  registered result
//   z      out  registered adder zero flag
//   v      out  registered adder signed-overflow flag
//   n      out  registered adder negative flag
module alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [5:0]       alufn,
  output logic [WIDTH-1:0] out,
  output logic             z,
  output logic             v,
  output logic             n
);

  localparam int S = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    UNIT_ARITH = 2'b00,
    UNIT_BOOL  = 2'b01,
    UNIT_SHIFT = 2'b10,
    UNIT_CMP   = 2'b11
  } unit_e;

  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] cin;
  logic [WIDTH-1:0] sum;
  logic             sum_z;
  logic             sum_v;
  logic             sum_n;
  logic [WIDTH-1:0] product;
  logic [WIDTH-1:0] bool_res;
  logic [WIDTH-1:0] shift_res;
  logic [WIDTH-1:0] cmp_res;
  logic [WIDTH-1:0] result;
  logic [3:0]       truth;
  logic [S-1:0]     amt;
  logic             lt;

  // The adder runs for every function code; alufn[0] turns it into a
  // subtractor by inverting b and injecting a carry.
  always_comb begin
    bx    = b ^ {WIDTH{alufn[0]}};
    cin   = '0;
    cin[0] = alufn[0];
    sum   = a + bx + cin;
    sum_z = (sum == '0);
    sum_n = sum[WIDTH-1];
    sum_v = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end

  // Low half of the product is the same for signed and unsigned operands.
  always_comb begin
    product = a * b;
  end

  // alufn[3:0] is a truth table indexed by {b[i], a[i]}.
  always_comb begin
    truth    = alufn[3:0];
    bool_res = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bool_res[i] = truth[{b[i], a[i]}];
    end
  end

  always_comb begin
    amt = b[S-1:0];
    if (!alufn[0]) begin
      shift_res = a << amt;
    end else if (alufn[1]) begin
      shift_res = $unsigned($signed(a) >>> amt);
    end else begin
      shift_res = a >> amt;
    end
  end

  always_comb begin
    lt      = sum_n ^ sum_v;
    cmp_res = '0;
    case (alufn[2:1])
      2'b01:   cmp_res[0] = sum_z;
      2'b10:   cmp_res[0] = lt;
      2'b11:   cmp_res[0] = sum_z | lt;
      default: cmp_res[0] = 1'b0;
    endcase
  end

  always_comb begin
    case (unit_e'(alufn[5:4]))
      UNIT_ARITH: result = alufn[1] ? product : sum;
      UNIT_BOOL:  result = bool_res;
      UNIT_SHIFT: result = shift_res;
      UNIT_CMP:   result = cmp_res;
      default:    result = sum;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
      z   <= 1'b0;
      v   <= 1'b0;
      n   <= 1'b0;
    end else begin
      out <= result;
      z   <= sum_z;
      v   <= sum_v;
      n   <= sum_n;
    end
  end

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - directed self-checking bench for alu
module tb_alu;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_MUL   = 6'b000010;
  localparam logic [5:0] OP_AND   = 6'b011000;
  localparam logic [5:0] OP_OR    = 6'b011110;
  localparam logic [5:0] OP_XOR   = 6'b010110;
  localparam logic [5:0] OP_A     = 6'b011010;
  localparam logic [5:0] OP_NOR   = 6'b010001;
  localparam logic [5:0] OP_SHL   = 6'b100000;
  localparam logic [5:0] OP_SHL2  = 6'b100010;
  localparam logic [5:0] OP_SHR   = 6'b100001;
  localparam logic [5:0] OP_SRA   = 6'b100011;
  localparam logic [5:0] OP_CMPEQ = 6'b110011;
  localparam logic [5:0] OP_CMPLT = 6'b110101;
  localparam logic [5:0] OP_CMPLE = 6'b110111;
  localparam logic [5:0] OP_CMP0  = 6'b110001;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [5:0]  alufn;
  logic [31:0] out;
  logic        z;
  logic        v;
  logic        n;

  int checks;
  int errors;

  alu #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .alufn (alufn),
    .out   (out),
    .z     (z),
    .v     (v),
    .n     (n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Present one operation in the low phase, then return 1 time unit after
  // the capturing edge so outputs can be sampled away from the edge.
  task automatic drive(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    alufn = f;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({out, z, v, n} !== 35'd0) begin
      errors++;
      $display("FAIL reset_initial out=%h z=%b v=%b n=%b required 0", out, z, v, n);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(OP_ADD, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    checks++;
    if (out !== 32'hFFFF_FFFE || n !== 1'b1 || v !== 1'b1 || z !== 1'b0) begin
      errors++;
      $display("FAIL reset_add out=%h z=%b v=%b n=%b required fffffffe 0 1 1", out, z, v, n);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out, z, v, n} !== 35'd0) begin
      errors++;
      $display("FAIL reset_async out=%h z=%b v=%b n=%b required 0", out, z, v, n);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if ({out, z, v, n} !== 35'd0) begin
      errors++;
      $display("FAIL reset_release_hold out=%h z=%b v=%b n=%b required 0", out, z, v, n);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out !== 32'hFFFF_FFFE || n !== 1'b1 || v !== 1'b1 || z !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_capture out=%h z=%b v=%b n=%b required fffffffe 0 1 1", out, z, v, n);
    end
  endtask

  task automatic test_arith;
    drive(OP_SUB, 32'h0000_0000, 32'h7FFF_FFFF);
    checks++;
    if (out !== 32'h8000_0001 || n !== 1'b1 || v !== 1'b0 || z !== 1'b0) begin
      errors++;
      $display("FAIL sub_neg out=%h z=%b v=%b n=%b required 80000001 0 0 1", out, z, v, n);
    end
    drive(OP_SUB, 32'h0101_FFFF, 32'h0000_0000);
    checks++;
    if (out !== 32'h0101_FFFF || z !== 1'b0 || n !== 1'b0 || v !== 1'b0) begin
      errors++;
      $display("FAIL sub_zero out=%h z=%b v=%b n=%b required 0101ffff 0 0 0", out, z, v, n);
    end
    drive(OP_MUL, 32'h0000_0001, 32'h3321_FFFF);
    checks++;
    if (out !== 32'h3321_FFFF || z !== 1'b0 || n !== 1'b0) begin
      errors++;
      $display("FAIL mul_one out=%h z=%b n=%b required 3321ffff 0 0", out, z, n);
    end
    drive(OP_MUL, 32'h0000_0000, 32'h0000_0000);
    checks++;
    if (out !== 32'h0000_0000 || z !== 1'b1) begin
      errors++;
      $display("FAIL mul_zero out=%h z=%b required 0 1", out, z);
    end
    drive(OP_MUL, 32'h0001_0003, 32'h0002_0005);
    checks++;
    if (out !== 32'h000B_000F) begin
      errors++;
      $display("FAIL mul_wrap out=%h required 000b000f", out);
    end
  endtask

  task automatic test_boolean;
    drive(OP_AND, 32'h1234_FFFF, 32'hEDCB_0000);
    checks++;
    if (out !== 32'h0000_0000) begin
      errors++;
      $display("FAIL and out=%h required 0", out);
    end
    drive(OP_OR, 32'h1234_FFFF, 32'hFFFF_FFFF);
    checks++;
    if (out !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL or out=%h required ffffffff", out);
    end
    drive(OP_XOR, 32'hABCD_4321, 32'hABCD_4321);
    checks++;
    if (out !== 32'h0000_0000) begin
      errors++;
      $display("FAIL xor out=%h required 0", out);
    end
    drive(OP_A, 32'h0871_ABCD, 32'hFFFF_FFFF);
    checks++;
    if (out !== 32'h0871_ABCD) begin
      errors++;
      $display("FAIL a_bypass out=%h required 0871abcd", out);
    end
    drive(OP_NOR, 32'hF0F0_F0F0, 32'hFF00_FF00);
    checks++;
    if (out !== 32'h000F_000F) begin
      errors++;
      $display("FAIL nor out=%h required 000f000f", out);
    end
  endtask

  task automatic test_shift;
    drive(OP_SHL, 32'h0871_ABCD, 32'd0);
    checks++;
    if (out !== 32'h0871_ABCD) begin
      errors++;
      $display("FAIL shl_0 out=%h required 0871abcd", out);
    end
    drive(OP_SHL, 32'h0871_ABCD, 32'd15);
    checks++;
    if (out !== 32'hD5E6_8000) begin
      errors++;
      $display("FAIL shl_15 out=%h required d5e68000", out);
    end
    drive(OP_SHR, 32'hFFFF_FFFF, 32'd10);
    checks++;
    if (out !== 32'h003F_FFFF) begin
      errors++;
      $display("FAIL shr_10 out=%h required 003fffff", out);
    end
    drive(OP_SRA, 32'hFFFF_FFFF, 32'd10);
    checks++;
    if (out !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL sra_10 out=%h required ffffffff", out);
    end
    drive(OP_SRA, 32'h8000_0000, 32'd31);
    checks++;
    if (out !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL sra_31 out=%h required ffffffff", out);
    end
    drive(OP_SHL, 32'h0871_ABCD, 32'h0000_002F);
    checks++;
    if (out !== 32'hD5E6_8000) begin
      errors++;
      $display("FAIL shl_upper_ignored out=%h required d5e68000", out);
    end
    drive(OP_SHL2, 32'h0871_ABCD, 32'd15);
    checks++;
    if (out !== 32'hD5E6_8000) begin
      errors++;
      $display("FAIL shl_alt out=%h required d5e68000", out);
    end
  endtask

  task automatic test_compare;
    drive(OP_CMPEQ, 32'h0871_ABCD, 32'h0871_ABCD);
    checks++;
    if (out !== 32'd1 || z !== 1'b1) begin
      errors++;
      $display("FAIL cmpeq_eq out=%h z=%b required 1 1", out, z);
    end
    drive(OP_CMPEQ, 32'h0871_ABCD, 32'hABCD_4321);
    checks++;
    if (out !== 32'd0) begin
      errors++;
      $display("FAIL cmpeq_ne out=%h required 0", out);
    end
    drive(OP_CMPLT, 32'h0871_ABCD, 32'h0A71_ABCD);
    checks++;
    if (out !== 32'd1) begin
      errors++;
      $display("FAIL cmplt_true out=%h required 1", out);
    end
    drive(OP_CMPLT, 32'h0A71_ABCD, 32'h0871_ABCD);
    checks++;
    if (out !== 32'd0) begin
      errors++;
      $display("FAIL cmplt_false out=%h required 0", out);
    end
    drive(OP_CMPLE, 32'h0871_ABCD, 32'h0871_ABCD);
    checks++;
    if (out !== 32'd1) begin
      errors++;
      $display("FAIL cmple_eq out=%h required 1", out);
    end
    drive(OP_CMPLT, 32'h8000_0000, 32'h7FFF_FFFF);
    checks++;
    if (out !== 32'd1 || v !== 1'b1 || n !== 1'b0) begin
      errors++;
      $display("FAIL cmplt_ovf out=%h v=%b n=%b required 1 1 0", out, v, n);
    end
    drive(OP_CMP0, 32'h0000_0005, 32'h0000_0005);
    checks++;
    if (out !== 32'd0 || z !== 1'b1) begin
      errors++;
      $display("FAIL cmp_none out=%h z=%b required 0 1", out, z);
    end
  endtask

  task automatic test_back_to_back;
    drive(OP_ADD, 32'h0000_0001, 32'h0000_0002);
    checks++;
    if (out !== 32'h0000_0003) begin
      errors++;
      $display("FAIL b2b_add out=%h required 00000003", out);
    end
    drive(OP_XOR, 32'hFF00_FF00, 32'h0F0F_0F0F);
    checks++;
    if (out !== 32'hF00F_F00F) begin
      errors++;
      $display("FAIL b2b_xor out=%h required f00ff00f", out);
    end
    drive(OP_SRA, 32'h8000_0000, 32'h0000_0004);
    checks++;
    if (out !== 32'hF800_0000) begin
      errors++;
      $display("FAIL b2b_sra out=%h required f8000000", out);
    end
    drive(OP_CMPLE, 32'h0000_0003, 32'h0000_0005);
    checks++;
    if (out !== 32'd1) begin
      errors++;
      $display("FAIL b2b_cmple out=%h required 1", out);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    a      = '0;
    b      = '0;
    alufn  = '0;
    test_reset();
    test_arith();
    test_boolean();
    test_shift();
    test_compare();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
